// File: rtl/riscv_pkg.sv
// Shared RV32I encodings (opcodes, ALU control, result-source select) and
// decode helpers used by the fetch, decode and execute stages.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALUCTL_ADD = 3'b000;
    localparam logic [2:0] ALUCTL_SUB = 3'b001;
    localparam logic [2:0] ALUCTL_AND = 3'b010;
    localparam logic [2:0] ALUCTL_OR  = 3'b011;
    localparam logic [2:0] ALUCTL_SLT = 3'b101;

    localparam logic [1:0] RESSRC_ALU = 2'b00;
    localparam logic [1:0] RESSRC_MEM = 2'b01;
    localparam logic [1:0] RESSRC_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic [2:0] alu_control;
    } ctrl_t;

    // Only the R-type opcode (op[5]=1) can select subtract on funct3=000.
    function automatic logic [2:0] alu_decode(input logic [2:0] funct3,
                                              input logic       op5,
                                              input logic       funct7_5);
        case (funct3)
            3'b000:  return (op5 & funct7_5) ? ALUCTL_SUB : ALUCTL_ADD;
            3'b010:  return ALUCTL_SLT;
            3'b110:  return ALUCTL_OR;
            3'b111:  return ALUCTL_AND;
            default: return ALUCTL_ADD;
        endcase
    endfunction

    function automatic logic [31:0] imm_extend(input logic [31:7] ib,
                                               input imm_fmt_e    fmt);
        case (fmt)
            IMM_I:   return {{20{ib[31]}}, ib[31:20]};
            IMM_S:   return {{20{ib[31]}}, ib[31:25], ib[11:7]};
            IMM_B:   return {{20{ib[31]}}, ib[7], ib[30:25], ib[11:8], 1'b0};
            IMM_J:   return {{12{ib[31]}}, ib[19:12], ib[20], ib[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// Architectural register file: two combinational read ports, one write port,
// async clear; x0 is hard-wired to zero.
module register_file #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    localparam int unsigned DEPTH = 1 << REG_AW;

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        rd1 = (ra1 == '0) ? '0 : regs[ra1];
        rd2 = (ra2 == '0) ? '0 : regs[ra2];
    end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, immediate extend, register file and the
// ID/EX register. Define DECODE_WB_BYPASS_EN to forward write-back data to operands.
module decode_cycle
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       InstrD,
    input  logic [31:0]       PCD,
    input  logic [31:0]       PCPlus4D,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RDW,
    input  logic [DATA_W-1:0] ResultW,
    input  logic              FlushE,
    output logic              RegWriteE,
    output logic [1:0]        ResultSrcE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [2:0]        ALUControlE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [REG_AW-1:0] RS1E,
    output logic [REG_AW-1:0] RS2E,
    output logic [REG_AW-1:0] RDE,
    output logic [31:0]       PCE,
    output logic [31:0]       PCPlus4E
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] rf_rd1;
    logic [DATA_W-1:0] rf_rd2;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] imm_ext;
    ctrl_t             ctrl;
    imm_fmt_e          imm_fmt;

    assign opcode = InstrD[6:0];
    assign funct3 = InstrD[14:12];
    assign rs1    = InstrD[19:15];
    assign rs2    = InstrD[24:20];
    assign rd     = InstrD[11:7];

    register_file #(
        .DATA_W(DATA_W),
        .REG_AW(REG_AW)
    ) u_register_file (
        .clock(clock),
        .reset(reset),
        .ra1  (rs1),
        .ra2  (rs2),
        .rd1  (rf_rd1),
        .rd2  (rf_rd2),
        .we   (RegWriteW),
        .wa   (RDW),
        .wd   (ResultW)
    );

`ifdef DECODE_WB_BYPASS_EN
    // Forwarding write-back data lets ID/EX capture the value written at this same edge.
    always_comb begin
        op_a = (RegWriteW && (RDW != '0) && (RDW == rs1)) ? ResultW : rf_rd1;
        op_b = (RegWriteW && (RDW != '0) && (RDW == rs2)) ? ResultW : rf_rd2;
    end
`else
    always_comb begin
        op_a = rf_rd1;
        op_b = rf_rd2;
    end
`endif

    always_comb begin
        ctrl    = '0;
        imm_fmt = IMM_NONE;
        case (opcode)
            OP_LOAD: begin
                ctrl.reg_write   = 1'b1;
                ctrl.result_src  = RESSRC_MEM;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALUCTL_ADD;
                imm_fmt          = IMM_I;
            end
            OP_STORE: begin
                ctrl.mem_write   = 1'b1;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = ALUCTL_ADD;
                imm_fmt          = IMM_S;
            end
            OP_RTYPE: begin
                ctrl.reg_write   = 1'b1;
                ctrl.result_src  = RESSRC_ALU;
                ctrl.alu_control = alu_decode(funct3, opcode[5], InstrD[30]);
            end
            OP_ITYPE: begin
                ctrl.reg_write   = 1'b1;
                ctrl.result_src  = RESSRC_ALU;
                ctrl.alu_src     = 1'b1;
                ctrl.alu_control = alu_decode(funct3, opcode[5], InstrD[30]);
                imm_fmt          = IMM_I;
            end
            OP_BRANCH: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = ALUCTL_SUB;
                imm_fmt          = IMM_B;
            end
            OP_JAL: begin
                ctrl.jump        = 1'b1;
                ctrl.reg_write   = 1'b1;
                ctrl.result_src  = RESSRC_PC4;
                ctrl.alu_control = ALUCTL_ADD;
                imm_fmt          = IMM_J;
            end
            default: begin
                ctrl    = '0;
                imm_fmt = IMM_NONE;
            end
        endcase
        imm_ext = DATA_W'($signed(imm_extend(InstrD[31:7], imm_fmt)));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset || FlushE) begin
            RegWriteE   <= 1'b0;
            ResultSrcE  <= '0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            RS1E        <= '0;
            RS2E        <= '0;
            RDE         <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
        end else begin
            RegWriteE   <= ctrl.reg_write;
            ResultSrcE  <= ctrl.result_src;
            MemWriteE   <= ctrl.mem_write;
            JumpE       <= ctrl.jump;
            BranchE     <= ctrl.branch;
            ALUSrcE     <= ctrl.alu_src;
            ALUControlE <= ctrl.alu_control;
            RD1E        <= op_a;
            RD2E        <= op_b;
            ImmExtE     <= imm_ext;
            RS1E        <= rs1;
            RS2E        <= rs2;
            RDE         <= rd;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule
